// File: rtl/intc_unit.sv
// ---------------------------------------------------------------------------
// intc_unit -- interrupt controller for the NeonFox core.
//
// Collects up to N_SRC external interrupt lines. A rising edge on a line
// latches it as pending, pending bits are masked by a software enable
// register, and the lowest-index active source is presented to the core on
// int_rq/int_addr. int_rq always drops for at least one cycle between
// requests so the core's rising-edge detector sees each interrupt.
//
// IO-space registers (BASE_ADDR + offset):
//   +0 ENABLE  r/w mask
//   +1 PENDING read, write-1-to-clear
//   +2 CAUSE   read-only: bit15 = request asserted, [3:0] = int_addr
//   +3 SWTRIG  write-1-to-set pending, reads 0
// Writes are byte-gated by H_en/L_en.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   src[N_SRC]      interrupt source lines (rising edge requests)
//   IO_address      core IO address
//   IO_wren/IO_ren  core IO write strobe / read enable
//   H_en/L_en       high/low byte write enables
//   data_out        core write data
//   IO_rdata        combinational read data (0 when not addressed/read)
//   int_rq          registered interrupt request
//   int_addr        registered index of the presented source
//
// Build option: define INTC_SYNC_EN to put a two-flop synchronizer on each
// src bit ahead of the edge detector (adds 2 cycles of latency).
// ---------------------------------------------------------------------------
module intc_unit #(
    parameter int          N_SRC     = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic [15:0]      IO_address,
    input  logic             IO_wren,
    input  logic             IO_ren,
    input  logic             H_en,
    input  logic             L_en,
    input  logic [15:0]      data_out,
    output logic [15:0]      IO_rdata,
    output logic             int_rq,
    output logic [3:0]       int_addr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_int_rq;
    logic [3:0]       r_int_addr;

    logic [N_SRC-1:0] r_prev_src;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_pending;

    logic [N_SRC-1:0] w_src_det;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_wdata;
    logic [N_SRC-1:0] w_be;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_swtrig;
    logic [N_SRC-1:0] w_enable_next;
    logic [N_SRC-1:0] w_pending_next;
    logic [N_SRC-1:0] w_active_n;
    logic [N_SRC-1:0] w_active_next_n;

    logic [15:0]      w_be16;
    logic [15:0]      w_wdata16;
    logic [15:0]      w_enable16;
    logic [15:0]      w_pending16;
    logic [15:0]      w_active16;
    logic [15:0]      w_active_next16;
    logic [3:0]       w_sel;
    logic [3:0]       w_wr_sel;
    logic [3:0]       w_winner;
    logic             w_any;

    // -----------------------------------------------------------------------
    // Source conditioning
    // -----------------------------------------------------------------------
`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;

    // Synchronizer resets to ones, matching prev_src, so lines that are high
    // when reset releases never look like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end
    assign w_src_det = r_sync2;
`else
    assign w_src_det = src;
`endif

    assign w_rise = w_src_det & ~r_prev_src;

    // -----------------------------------------------------------------------
    // Address decode and byte-gated write data
    // -----------------------------------------------------------------------
    assign w_be16    = {{8{H_en}}, {8{L_en}}};
    assign w_wdata16 = data_out & w_be16;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sel
        assign w_sel[gi] = (IO_address == BASE_ADDR + 16'(gi));
    end
    assign w_wr_sel = w_sel & {4{IO_wren}};

    // Narrow write data to the implemented sources and zero-extend the
    // register images back to 16 bits for readback and indexing.
    for (genvar gi = 0; gi < 16; gi++) begin : g_bits
        if (gi < N_SRC) begin : g_used
            assign w_wdata[gi]         = w_wdata16[gi];
            assign w_be[gi]            = w_be16[gi];
            assign w_enable16[gi]      = r_enable[gi];
            assign w_pending16[gi]     = r_pending[gi];
            assign w_active16[gi]      = w_active_n[gi];
            assign w_active_next16[gi] = w_active_next_n[gi];
        end else begin : g_unused
            assign w_enable16[gi]      = 1'b0;
            assign w_pending16[gi]     = 1'b0;
            assign w_active16[gi]      = 1'b0;
            assign w_active_next16[gi] = 1'b0;
        end
    end

    assign w_enable_next  = w_wr_sel[0] ? ((r_enable & ~w_be) | w_wdata) : r_enable;
    assign w_w1c          = w_wr_sel[1] ? w_wdata : '0;
    assign w_swtrig       = w_wr_sel[3] ? w_wdata : '0;
    // Set terms are OR'd after the clear so a same-cycle edge survives W1C.
    assign w_pending_next = (r_pending & ~w_w1c) | w_rise | w_swtrig;

    assign w_active_n      = r_pending & r_enable;
    assign w_active_next_n = w_pending_next & w_enable_next;

    // -----------------------------------------------------------------------
    // Priority encoder: lowest active index wins
    // -----------------------------------------------------------------------
    always_comb begin
        w_winner = 4'd0;
        w_any    = |w_active16;
        for (int i = 15; i >= 0; i--) begin
            if (w_active16[i]) begin
                w_winner = 4'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request state machine
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Look at the post-write active set so a W1C or disable
                // drops the request on the same edge the write lands.
                if (!w_active_next16[r_int_addr]) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_int_rq   <= 1'b0;
            r_int_addr <= 4'd0;
            r_prev_src <= '1;
            r_enable   <= '0;
            r_pending  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_int_rq   <= (w_state_next == ST_ASSERT);
            r_prev_src <= w_src_det;
            r_enable   <= w_enable_next;
            r_pending  <= w_pending_next;
            // The presented index is captured only when leaving IDLE and
            // stays frozen through ASSERT and GAP.
            if (r_state == ST_IDLE && w_any) begin
                r_int_addr <= w_winner;
            end
        end
    end

    assign int_rq   = r_int_rq;
    assign int_addr = r_int_addr;

    // -----------------------------------------------------------------------
    // Combinational read mux
    // -----------------------------------------------------------------------
    always_comb begin
        IO_rdata = 16'h0000;
        if (IO_ren) begin
            if (w_sel[0]) begin
                IO_rdata = w_enable16;
            end else if (w_sel[1]) begin
                IO_rdata = w_pending16;
            end else if (w_sel[2]) begin
                IO_rdata = {(r_state == ST_ASSERT), 11'd0, r_int_addr};
            end
        end
    end

endmodule

// File: tb/tb_intc_unit.sv
// ---------------------------------------------------------------------------
// tb_intc_unit -- directed, table-driven bench for intc_unit (default build,
// src fed straight into the edge detector).
//
// Each table row is one clock cycle: inputs are driven just after a rising
// edge, the next rising edge is taken, and 1 time unit later int_rq/int_addr
// (and optionally IO_rdata for the row's read address) are compared with
// hand-computed values. A separate hand-written sequence covers reset in
// the middle of an asserted request.
// ---------------------------------------------------------------------------
module tb_intc_unit;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        rst;
    logic [15:0] src;
    logic [15:0] IO_address;
    logic        IO_wren;
    logic        IO_ren;
    logic        H_en;
    logic        L_en;
    logic [15:0] data_out;
    logic [15:0] IO_rdata;
    logic        int_rq;
    logic [3:0]  int_addr;

    int n_checks = 0;
    int n_errors = 0;

    intc_unit #(
        .N_SRC     (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .IO_address (IO_address),
        .IO_wren    (IO_wren),
        .IO_ren     (IO_ren),
        .H_en       (H_en),
        .L_en       (L_en),
        .data_out   (data_out),
        .IO_rdata   (IO_rdata),
        .int_rq     (int_rq),
        .int_addr   (int_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] src;
        logic        wr;
        logic        rd;
        logic [1:0]  off;
        logic        h;
        logic        l;
        logic [15:0] data;
        logic        exp_rq;
        logic [3:0]  exp_addr;
        logic        chk_rd;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    // Cycle with nothing on the bus
    function automatic vec_t idle(input logic [15:0] s, input logic rq, input logic [3:0] a);
        vec_t v;
        v = '{rst: 1'b0, src: s, wr: 1'b0, rd: 1'b0, off: 2'd0, h: 1'b0, l: 1'b0,
              data: 16'h0, exp_rq: rq, exp_addr: a, chk_rd: 1'b0, exp_rdata: 16'h0};
        return v;
    endfunction

    function automatic vec_t wr(input logic [15:0] s, input logic [1:0] o, input logic hh,
                                input logic ll, input logic [15:0] d,
                                input logic rq, input logic [3:0] a);
        vec_t v;
        v = idle(s, rq, a);
        v.wr = 1'b1; v.off = o; v.h = hh; v.l = ll; v.data = d;
        return v;
    endfunction

    function automatic vec_t rd(input logic [15:0] s, input logic [1:0] o,
                                input logic [15:0] e, input logic rq, input logic [3:0] a);
        vec_t v;
        v = idle(s, rq, a);
        v.rd = 1'b1; v.off = o; v.chk_rd = 1'b1; v.exp_rdata = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive_idle();
        IO_wren = 1'b0; IO_ren = 1'b0; H_en = 1'b0; L_en = 1'b0;
        data_out = 16'h0; IO_address = 16'h0000;
    endtask

    task automatic bus_read(input logic [1:0] o, input string name, input logic [15:0] want);
        IO_ren = 1'b1; IO_address = BASE + 16'(o);
        #1;
        check(name, IO_rdata, want);
        $display("read  off=%0d rdata=%h", o, IO_rdata);
        IO_ren = 1'b0;
    endtask

    initial begin
        logic rq_seen;
        int   waited;

        rst = 1'b1; src = 16'h0001;
        drive_idle();

        // ---- Reset / idle: src[0] held high across reset ----
        vecs.push_back('{rst: 1'b1, src: 16'h0001, wr: 1'b0, rd: 1'b1, off: 2'd1, h: 1'b0,
                         l: 1'b0, data: 16'h0, exp_rq: 1'b0, exp_addr: 4'd0, chk_rd: 1'b1,
                         exp_rdata: 16'h0000});
        vecs.push_back('{rst: 1'b1, src: 16'h0001, wr: 1'b0, rd: 1'b0, off: 2'd0, h: 1'b0,
                         l: 1'b0, data: 16'h0, exp_rq: 1'b0, exp_addr: 4'd0, chk_rd: 1'b0,
                         exp_rdata: 16'h0000});
        vecs.push_back(wr(16'h0001, 2'd0, 1, 1, 16'hFFFF, 0, 4'd0));
        vecs.push_back(rd(16'h0001, 2'd0, 16'hFFFF, 0, 4'd0));
        vecs.push_back(rd(16'h0001, 2'd1, 16'h0000, 0, 4'd0));
        vecs.push_back(idle(16'h0000, 0, 4'd0));
        // ---- Basic request on src[5] ----
        vecs.push_back(wr(16'h0000, 2'd0, 1, 1, 16'h0020, 0, 4'd0));
        vecs.push_back(idle(16'h0020, 0, 4'd0));               // edge sampled
        vecs.push_back(rd(16'h0020, 2'd2, 16'h8005, 1, 4'd5)); // request 2 cycles on
        vecs.push_back(rd(16'h0000, 2'd1, 16'h0020, 1, 4'd5));
        vecs.push_back(wr(16'h0000, 2'd1, 1, 1, 16'h0020, 0, 4'd5)); // W1C -> GAP
        vecs.push_back(rd(16'h0000, 2'd2, 16'h0005, 0, 4'd5));
        vecs.push_back(idle(16'h0000, 0, 4'd5));
        // ---- Priority / no preempt ----
        vecs.push_back(wr(16'h0000, 2'd0, 1, 1, 16'hFFFF, 0, 4'd5));
        vecs.push_back(idle(16'h0200, 0, 4'd5));
        vecs.push_back(idle(16'h0200, 1, 4'd9));
        vecs.push_back(idle(16'h0204, 1, 4'd9));               // src[2] while ASSERT
        vecs.push_back(rd(16'h0204, 2'd1, 16'h0204, 1, 4'd9));
        vecs.push_back(wr(16'h0204, 2'd1, 1, 1, 16'h0200, 0, 4'd9)); // low cycle 1
        vecs.push_back(idle(16'h0204, 0, 4'd9));                      // low cycle 2
        vecs.push_back(idle(16'h0204, 1, 4'd2));
        vecs.push_back(wr(16'h0000, 2'd1, 1, 1, 16'h0004, 0, 4'd2));
        vecs.push_back(idle(16'h0000, 0, 4'd2));
        vecs.push_back(rd(16'h0000, 2'd1, 16'h0000, 0, 4'd2));
        // ---- Mask ----
        vecs.push_back(wr(16'h0000, 2'd0, 1, 1, 16'h0000, 0, 4'd2));
        vecs.push_back(idle(16'h0008, 0, 4'd2));
        vecs.push_back(rd(16'h0008, 2'd1, 16'h0008, 0, 4'd2));
        vecs.push_back(wr(16'h0008, 2'd0, 1, 1, 16'h0008, 0, 4'd2));
        vecs.push_back(idle(16'h0008, 1, 4'd3));                // 1 cycle after write
        vecs.push_back(wr(16'h0000, 2'd0, 1, 1, 16'h0000, 0, 4'd3)); // disable exits
        vecs.push_back(idle(16'h0000, 0, 4'd3));
        vecs.push_back(rd(16'h0000, 2'd1, 16'h0008, 0, 4'd3));
        vecs.push_back(wr(16'h0000, 2'd1, 1, 1, 16'h0008, 0, 4'd3));
        vecs.push_back(rd(16'h0000, 2'd1, 16'h0000, 0, 4'd3));
        // ---- Byte enables / SWTRIG / set-clear collision ----
        vecs.push_back(wr(16'h0000, 2'd3, 1, 0, 16'hFFFF, 0, 4'd3));
        vecs.push_back(rd(16'h0000, 2'd1, 16'hFF00, 0, 4'd3));
        vecs.push_back(rd(16'h0000, 2'd3, 16'h0000, 0, 4'd3));
        vecs.push_back(wr(16'h0000, 2'd1, 1, 1, 16'hFFFF, 0, 4'd3));
        vecs.push_back(idle(16'h0010, 0, 4'd3));
        vecs.push_back(idle(16'h0000, 0, 4'd3));
        vecs.push_back(wr(16'h0010, 2'd1, 1, 1, 16'h0010, 0, 4'd3)); // W1C + edge
        vecs.push_back(rd(16'h0000, 2'd1, 16'h0010, 0, 4'd3));
        vecs.push_back(wr(16'h0000, 2'd0, 0, 1, 16'hFFFF, 0, 4'd3)); // low byte only
        vecs.push_back(rd(16'h0000, 2'd0, 16'h00FF, 1, 4'd4));
        vecs.push_back(wr(16'h0000, 2'd1, 1, 0, 16'h0010, 1, 4'd4)); // gated off
        vecs.push_back(wr(16'h0000, 2'd1, 0, 1, 16'h0010, 0, 4'd4));
        vecs.push_back(idle(16'h0000, 0, 4'd4));
        vecs.push_back(rd(16'h0000, 2'd1, 16'h0000, 0, 4'd4));

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            src        = vecs[i].src;
            IO_wren    = vecs[i].wr;
            IO_ren     = vecs[i].rd;
            IO_address = BASE + 16'(vecs[i].off);
            H_en       = vecs[i].h;
            L_en       = vecs[i].l;
            data_out   = vecs[i].data;
            @(posedge clk);
            #1;
            IO_wren = 1'b0;   // a write must land on exactly one edge
            check($sformatf("vec%0d int_rq", i), 16'(int_rq), 16'(vecs[i].exp_rq));
            check($sformatf("vec%0d int_addr", i), 16'(int_addr), 16'(vecs[i].exp_addr));
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d rdata", i), IO_rdata, vecs[i].exp_rdata);
            end
            $display("vec%0d rst=%b src=%h wr=%b rd=%b off=%0d be=%b%b d=%h -> rq=%b addr=%0d rdata=%h",
                     i, vecs[i].rst, vecs[i].src, vecs[i].wr, vecs[i].rd, vecs[i].off,
                     vecs[i].h, vecs[i].l, vecs[i].data, int_rq, int_addr, IO_rdata);
        end
        drive_idle();

        // ---- Reset mid-ASSERT with int_addr = 7 (ENABLE is 16'h00FF) ----
        src = 16'h0080;
        rq_seen = 1'b0;
        waited  = 0;
        while (!rq_seen && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
            rq_seen = int_rq;
        end
        check("rst_seq latency", 16'(waited), 16'd2);
        check("rst_seq addr7", 16'(int_addr), 16'd7);
        $display("rst_seq rq after %0d cycles addr=%0d", waited, int_addr);
        bus_read(2'd2, "rst_seq cause", 16'h8007);

        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_seq rq", 16'(int_rq), 16'd0);
        check("rst_seq addr", 16'(int_addr), 16'd0);
        $display("rst_seq in reset rq=%b addr=%0d", int_rq, int_addr);
        rst = 1'b0;
        bus_read(2'd1, "rst_seq pending", 16'h0000);
        bus_read(2'd0, "rst_seq enable", 16'h0000);

        // src[7] stayed high through reset: no new request may appear.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        bus_read(2'd1, "rst_seq no_edge", 16'h0000);
        check("rst_seq quiet rq", 16'(int_rq), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/intc_unit.md
# intc_unit

Interrupt controller for the NeonFox core. It collects up to 16 external interrupt sources, edge-detects and latches them as pending, and masks them with a software enable register. It drives the core's `int_rq`/`int_addr` pair, presenting one interrupt at a time and guaranteeing a low cycle on `int_rq` between requests so the core's rising-edge detector sees every interrupt. It is software-visible as four IO-space registers on the core's IO bus.

## Interface
Parameters:
- `N_SRC`, 16: number of sources, 1..16. Unused upper bits read 0 and ignore writes.
- `BASE_ADDR`, 16'hFF00: IO address of register 0. Registers sit at `BASE_ADDR+0..+3`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high, sampled on rising `clk`.
- `src`  in  N_SRC  interrupt source lines. A rising edge requests an interrupt.
- `IO_address`  in  16  core IO address.
- `IO_wren`  in  1  core IO write strobe.
- `IO_ren`  in  1  core IO read enable.
- `H_en`  in  1  high-byte write enable.
- `L_en`  in  1  low-byte write enable.
- `data_out`  in  16  core write data.
- `IO_rdata`  out  16  read data. Combinational. 0 when not addressed or `IO_ren` low.
- `int_rq`  out  1  interrupt request to the core. Registered.
- `int_addr`  out  4  index of the presented source. Registered.

## Operation
- **Edge detect.** `prev_src` is registered each cycle. `rise = src & ~prev_src`. Reset loads `prev_src` with all ones, so lines already high at reset do not interrupt.
- **Registers** (write data is byte-gated by `H_en`/`L_en`):
  - +0 `ENABLE`: read/write mask.
  - +1 `PENDING`: readable. Writing 1 clears the bit (W1C).
  - +2 `CAUSE`: read-only. Bit15 = state is ASSERT. [3:0] = `int_addr`. Other bits 0.
  - +3 `SWTRIG`: write-only. Writing 1 sets the pending bit. Reads 0.
- **Pending update, per cycle:** `pending <= (pending & ~w1c) | rise | swtrig`. Set beats clear in the same cycle.
- **Selection.** `active = pending & ENABLE`. Priority encode with the lowest index winning.
- **State machine** (`int_rq` is high only in ASSERT):
  - IDLE: if `active != 0`, latch the winner index into `int_addr` and go to ASSERT.
  - ASSERT: `int_addr` is frozen. A higher-priority arrival does not preempt. Leave to GAP when `active[int_addr]` becomes 0, whether by W1C or by disabling the bit.
  - GAP: one cycle, `int_rq` low, then go to IDLE unconditionally.
- Reads have no side effects.
- **Reset values:** `int_rq`=0, `int_addr`=0, state IDLE, `ENABLE`=0, `PENDING`=0, `prev_src`=all ones.
- Reset mid-ASSERT drops `int_rq` on the next edge and clears all pending requests.

## Timing
- A rising edge on `src[i]` sampled at edge k sets `PENDING[i]` after edge k. If `ENABLE[i]` is set and the state is IDLE, `int_rq` and `int_addr` are valid after edge k+1. Latency is 2 cycles from input change to `int_rq`.
- W1C of the presented bit at edge k: state is GAP after k, `int_rq` is low after k. IDLE follows after k+1. The next request can be high after k+2. Minimum low time is 2 cycles when another interrupt is already pending.
- Writing the register during the same cycle as a new edge on the same bit leaves the bit pending.
- Combinational read: `IO_rdata` reflects register state in the same cycle as `IO_ren`/`IO_address`. The core captures it on the next edge.
- A write takes effect after the rising edge on which `IO_wren` is sampled.

## Configuration
- `INTC_SYNC_EN`:
  - Defined: each `src` bit passes through a two-flop synchronizer before edge detect. Synchronizer flops reset to all ones. Latency from `src` to `int_rq` becomes 4 cycles.
  - Undefined: `src` is assumed synchronous to `clk` and feeds edge detect directly (2-cycle latency).
  - Register behaviour is identical in both builds.

## Test plan
- **Reset/idle:** hold `src`=16'h0001 through reset, release, `ENABLE`=16'hFFFF -> `int_rq` stays 0 and `PENDING` reads 0.
- **Basic request:** `ENABLE`=16'h0020, pulse `src[5]` -> `int_rq`=1 and `int_addr`=5 two cycles later (four with `INTC_SYNC_EN`). `CAUSE` reads 16'h8005.
- **Priority/no-preempt:** `ENABLE`=16'hFFFF, raise `src[9]`, then `src[2]` while ASSERT -> `int_addr` stays 9. W1C 16'h0200 -> `int_rq` low for exactly 2 cycles, then high with `int_addr`=2.
- **Mask:** `src[3]` edge with `ENABLE`=0 -> `PENDING`=16'h0008, `int_rq`=0. Write `ENABLE`=16'h0008 -> `int_rq` high 1 cycle after the write.
- **Byte enables/SWTRIG:** write 16'hFFFF to `SWTRIG` with `H_en`=1, `L_en`=0 -> `PENDING`=16'hFF00. Set/clear collision: W1C bit 4 in the same cycle as a `src[4]` edge -> bit 4 remains 1.
- **Reset mid-operation:** assert `rst` while ASSERT with `int_addr`=7 -> after the edge `int_rq`=0, `int_addr`=0, `PENDING`=0, `ENABLE`=0.
